// File: rtl/alu_share_arbiter_if.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter_if
//   Bundle of every handshake/bus signal around alu_share_arbiter: the NREQ
//   requester ports, the shared-ALU ports and the registered response port.
//   The ALU opcode (alu_t) is carried as a 4-bit code. ADD is 4'h0. Any other
//   code passes through the arbiter untouched.
//
//   Modports
//     slave  : the arbiter itself
//     master : the surroundings (requesters, response consumer, ALU)
//
//   Optional: `ALU_ARB_PERF_EN adds perf_grant_cnt / perf_stall_cnt
//   (NREQ x 16 each, read-only, saturating).
// ---------------------------------------------------------------------------
interface alu_share_arbiter_if #(
    parameter int NREQ = 3,
    parameter int W    = 32
);
    localparam int IDW = $clog2(NREQ);

    // Requester side
    logic [NREQ-1:0]          req_valid;
    logic [NREQ-1:0]          req_ready;
    logic [NREQ-1:0][3:0]     req_alu_ctrl;
    logic [NREQ-1:0][W-1:0]   req_op1;
    logic [NREQ-1:0][W-1:0]   req_op2;
    logic [NREQ-1:0]          req_lui;

    // Shared ALU side
    logic [3:0]               alu_ctrl;
    logic [W-1:0]             alu_op1;
    logic [W-1:0]             alu_op2;
    logic                     alu_lui;
    logic [W-1:0]             alu_result;
    logic                     alu_zero;

    // Response side
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [IDW-1:0]           rsp_id;
    logic [W-1:0]             rsp_result;
    logic                     rsp_zero;

`ifdef ALU_ARB_PERF_EN
    logic [NREQ-1:0][15:0]    perf_grant_cnt;
    logic [NREQ-1:0][15:0]    perf_stall_cnt;
`endif

    modport slave (
        input  req_valid, req_alu_ctrl, req_op1, req_op2, req_lui,
        output req_ready,
        output alu_ctrl, alu_op1, alu_op2, alu_lui,
        input  alu_result, alu_zero,
        output rsp_valid, rsp_id, rsp_result, rsp_zero,
        input  rsp_ready
`ifdef ALU_ARB_PERF_EN
        ,
        output perf_grant_cnt, perf_stall_cnt
`endif
    );

    modport master (
        output req_valid, req_alu_ctrl, req_op1, req_op2, req_lui,
        input  req_ready,
        input  alu_ctrl, alu_op1, alu_op2, alu_lui,
        output alu_result, alu_zero,
        input  rsp_valid, rsp_id, rsp_result, rsp_zero,
        output rsp_ready
`ifdef ALU_ARB_PERF_EN
        ,
        input  perf_grant_cnt, perf_stall_cnt
`endif
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
//   Shares one combinational ALU among NREQ requesters. Round-robin grant,
//   one registered response slot, valid/ready on both sides, 1-cycle latency,
//   1 op/cycle while the consumer keeps rsp_ready high.
//
//   Ports
//     clk    : core clock, rising edge
//     reset  : asynchronous, active-high
//     bus    : alu_share_arbiter_if.slave (requesters, ALU, response)
//
//   Parameters
//     NREQ   : number of requesters (2..8)
//     W      : operand/result width (must match the ALU)
//
//   Optional feature macro: ALU_ARB_PERF_EN (per-requester grant/stall
//   counters, 16 bit, saturating).
// ---------------------------------------------------------------------------
module alu_share_arbiter #(
    parameter int NREQ = 3,
    parameter int W    = 32
) (
    input  logic               clk,
    input  logic               reset,
    alu_share_arbiter_if.slave bus
);
    localparam int         IDW     = $clog2(NREQ);
    localparam logic [3:0] ALU_ADD = 4'h0;

    logic           slot_free;
    logic           grant_found;
    logic [IDW-1:0] grant_idx;
    logic           accept;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] next_ptr;
    logic [IDW:0]   cand_sum;
    logic [IDW-1:0] cand;

    // The slot can be drained and refilled in the same cycle.
    assign slot_free = !bus.rsp_valid || bus.rsp_ready;
    // Reset gates the grant so req_ready drops the moment reset rises.
    assign accept    = grant_found && slot_free && !reset;

    // Round-robin search starting at rr_ptr; only req_valid is consulted,
    // never operands, so req_ready has no path from a requester's own data.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and a latch is never inferred.
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_sum    = '0;
        cand        = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand_sum = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (cand_sum >= (IDW+1)'(NREQ)) begin
                cand_sum = cand_sum - (IDW+1)'(NREQ);
            end
            cand = cand_sum[IDW-1:0];
            if (!grant_found && bus.req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        bus.alu_ctrl  = ALU_ADD;
        bus.alu_op1   = '0;
        bus.alu_op2   = '0;
        bus.alu_lui   = 1'b0;
        if (accept) begin
            bus.req_ready[grant_idx] = 1'b1;
            bus.alu_ctrl = bus.req_alu_ctrl[grant_idx];
            bus.alu_op1  = bus.req_op1[grant_idx];
            bus.alu_op2  = bus.req_op2[grant_idx];
            bus.alu_lui  = bus.req_lui[grant_idx];
        end
    end

    assign next_ptr = (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + 1'b1;

    // Response slot and round-robin pointer. Response fields keep their last
    // values when the slot empties; only rsp_valid falls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.rsp_valid  <= 1'b0;
            bus.rsp_id     <= '0;
            bus.rsp_result <= '0;
            bus.rsp_zero   <= 1'b0;
            rr_ptr         <= '0;
        end else if (accept) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            bus.rsp_valid  <= 1'b1;
            bus.rsp_id     <= grant_idx;
            bus.rsp_result <= bus.alu_result;
            bus.rsp_zero   <= bus.alu_zero;
            rr_ptr         <= next_ptr;
        end else if (bus.rsp_ready) begin
            bus.rsp_valid  <= 1'b0;
        end
    end

`ifdef ALU_ARB_PERF_EN
    // A grant of i is always an accept of i, so req_valid & req_ready counts
    // accepts; valid & !ready counts waiting cycles (backpressure included).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.perf_grant_cnt <= '0;
            bus.perf_stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i] &&
                    bus.perf_grant_cnt[i] != 16'hFFFF) begin
                    bus.perf_grant_cnt[i] <= bus.perf_grant_cnt[i] + 16'd1;
                end
                if (bus.req_valid[i] && !bus.req_ready[i] &&
                    bus.perf_stall_cnt[i] != 16'hFFFF) begin
                    bus.perf_stall_cnt[i] <= bus.perf_stall_cnt[i] + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_share_arbiter
//   Directed scenarios (single request, contention order, backpressure,
//   LUI path, asynchronous reset mid-operation, optional perf counters)
//   followed by randomized traffic. A behavioural ALU answers the DUT's ALU
//   port; a reference model predicts grants and responses from the
//   requesters' own operands.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_share_arbiter;
    localparam int NREQ = 3;
    localparam int W    = 32;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_SLT = 4'h5;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;

    alu_share_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

    alu_share_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: LUI passes op2; unknown opcodes yield a fixed default.
    function automatic logic [W-1:0] ref_alu(input logic [3:0] c,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b,
                                             input logic lui);
        if (lui) return b;
        case (c)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'hBAD0_C0DE;
        endcase
    endfunction

    assign bus.alu_result = ref_alu(bus.alu_ctrl, bus.alu_op1, bus.alu_op2, bus.alu_lui);
    assign bus.alu_zero   = (ref_alu(bus.alu_ctrl, bus.alu_op1, bus.alu_op2, bus.alu_lui) == '0);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference model state
    bit             m_valid;
    int             m_id;
    logic [W-1:0]   m_result;
    bit             m_zero;
    int             m_ptr;
    int             age [NREQ];
    logic [NREQ-1:0] obs_ready;

    // Pick the valid requester at the smallest circular distance from ptr.
    function automatic int ref_pick(input logic [NREQ-1:0] v, input int ptr);
        int best  = -1;
        int bestd = NREQ;
        for (int i = 0; i < NREQ; i++) begin
            if (v[i]) begin
                int d = (i - ptr + NREQ) % NREQ;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    task automatic model_reset();
        m_valid  = 1'b0;
        m_id     = 0;
        m_result = '0;
        m_zero   = 1'b0;
        m_ptr    = 0;
        for (int i = 0; i < NREQ; i++) age[i] = 0;
    endtask

    task automatic set_req(input int i, input bit v, input logic [3:0] c,
                           input logic [W-1:0] a, input logic [W-1:0] b, input bit lui);
        bus.req_valid[i]    = v;
        bus.req_alu_ctrl[i] = c;
        bus.req_op1[i]      = a;
        bus.req_op2[i]      = b;
        bus.req_lui[i]      = lui;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, OP_ADD, '0, '0, 1'b0);
    endtask

    // One clock: check outputs at the falling edge against the model, then
    // advance the model at the rising edge and return 1 ns later.
    task automatic step();
        int           g;
        bit           free;
        logic [3:0]   c;
        logic [W-1:0] a;
        logic [W-1:0] b;
        bit           l;
        @(negedge clk);
        check("rsp_valid",  64'(bus.rsp_valid),  64'(m_valid));
        check("rsp_id",     64'(bus.rsp_id),     64'(m_id));
        check("rsp_result", 64'(bus.rsp_result), 64'(m_result));
        check("rsp_zero",   64'(bus.rsp_zero),   64'(m_zero));
        free = !m_valid || bus.rsp_ready;
        g = free ? ref_pick(bus.req_valid, m_ptr) : -1;
        obs_ready = bus.req_ready;
        check("req_ready", 64'(bus.req_ready), (g < 0) ? 64'd0 : (64'd1 << g));
        if (g >= 0) begin
            c = bus.req_alu_ctrl[g];
            a = bus.req_op1[g];
            b = bus.req_op2[g];
            l = bus.req_lui[g];
            check("alu_ctrl", 64'(bus.alu_ctrl), 64'(c));
            check("alu_op1",  64'(bus.alu_op1),  64'(a));
            check("alu_op2",  64'(bus.alu_op2),  64'(b));
            check("alu_lui",  64'(bus.alu_lui),  64'(l));
            check("fairness", 64'(age[g] < NREQ), 64'd1);
            for (int i = 0; i < NREQ; i++) begin
                if (i == g || !bus.req_valid[i]) age[i] = 0;
                else age[i]++;
            end
        end else begin
            check("alu_idle_ctrl", 64'(bus.alu_ctrl), 64'(OP_ADD));
            check("alu_idle_op1",  64'(bus.alu_op1),  64'd0);
            for (int i = 0; i < NREQ; i++) if (!bus.req_valid[i]) age[i] = 0;
        end
        @(posedge clk);
        if (g >= 0) begin
            m_valid  = 1'b1;
            m_id     = g;
            m_result = ref_alu(c, a, b, l);
            m_zero   = (m_result == '0);
            m_ptr    = (g + 1) % NREQ;
        end else if (bus.rsp_ready) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_reqs();
        bus.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        model_reset();
        check("rst_rsp_valid",  64'(bus.rsp_valid),  64'd0);
        check("rst_rsp_id",     64'(bus.rsp_id),     64'd0);
        check("rst_rsp_result", 64'(bus.rsp_result), 64'd0);
        check("rst_req_ready",  64'(bus.req_ready),  64'd0);
    endtask

    logic [NREQ-1:0] grants [4];

    initial begin
        reset = 1'b1;
        clear_reqs();
        bus.rsp_ready = 1'b0;
        model_reset();

`ifdef ALU_ARB_PERF_EN
        // Perf counters: two requesters alternate for 4 cycles.
        do_reset();
        bus.rsp_ready = 1'b1;
        set_req(0, 1'b1, OP_ADD, 32'd1, 32'd2, 1'b0);
        set_req(1, 1'b1, OP_ADD, 32'd3, 32'd4, 1'b0);
        repeat (4) step();
        clear_reqs();
        check("perf_grant0", 64'(bus.perf_grant_cnt[0]), 64'd2);
        check("perf_grant1", 64'(bus.perf_grant_cnt[1]), 64'd2);
        check("perf_stall0", 64'(bus.perf_stall_cnt[0]), 64'd2);
        check("perf_stall1", 64'(bus.perf_stall_cnt[1]), 64'd2);
`endif

        // Single request: 5 + 7.
        do_reset();
        bus.rsp_ready = 1'b1;
        set_req(0, 1'b1, OP_ADD, 32'd5, 32'd7, 1'b0);
        step();
        check("t1_ready", 64'(obs_ready), 64'b001);
        clear_reqs();
        check("t1_valid",  64'(bus.rsp_valid),  64'd1);
        check("t1_id",     64'(bus.rsp_id),     64'd0);
        check("t1_result", 64'(bus.rsp_result), 64'd12);
        check("t1_zero",   64'(bus.rsp_zero),   64'd0);
        step();

        // Contention from reset: order 0,1,2,0.
        do_reset();
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, OP_ADD, $urandom, $urandom, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step();
            grants[k] = obs_ready;
        end
        check("t2_grant0", 64'(grants[0]), 64'b001);
        check("t2_grant1", 64'(grants[1]), 64'b010);
        check("t2_grant2", 64'(grants[2]), 64'b100);
        check("t2_grant3", 64'(grants[3]), 64'b001);
        clear_reqs();

        // Backpressure: 9-9 held for 3 cycles, then drain + refill.
        set_req(1, 1'b1, OP_SUB, 32'd9, 32'd9, 1'b0);
        step();
        clear_reqs();
        bus.rsp_ready = 1'b0;
        set_req(2, 1'b1, OP_ADD, 32'd3, 32'd4, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("t3_ready",  64'(obs_ready),      64'd0);
            check("t3_id",     64'(bus.rsp_id),     64'd1);
            check("t3_result", 64'(bus.rsp_result), 64'd0);
            check("t3_zero",   64'(bus.rsp_zero),   64'd1);
        end
        bus.rsp_ready = 1'b1;
        step();
        check("t3_refill_ready", 64'(obs_ready), 64'b100);
        clear_reqs();
        check("t3_refill_id",     64'(bus.rsp_id),     64'd2);
        check("t3_refill_result", 64'(bus.rsp_result), 64'd7);
        check("t3_refill_valid",  64'(bus.rsp_valid),  64'd1);

        // LUI path.
        set_req(2, 1'b1, OP_ADD, 32'h0000_DEAD, 32'h1234_5000, 1'b1);
        step();
        clear_reqs();
        check("t4_result", 64'(bus.rsp_result), 64'h1234_5000);
        check("t4_id",     64'(bus.rsp_id),     64'd2);

        // Reset between edges while a response is held.
        set_req(1, 1'b1, OP_ADD, 32'd1, 32'd1, 1'b0);
        step();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, OP_OR, $urandom, $urandom, 1'b0);
        bus.rsp_ready = 1'b0;
        step();
        check("t5_pre_valid", 64'(bus.rsp_valid), 64'd1);
        #1 reset = 1'b1;
        #1;
        check("t5_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("t5_req_ready", 64'(bus.req_ready), 64'd0);
        @(posedge clk);
        #3 reset = 1'b0;
        model_reset();
        bus.rsp_ready = 1'b1;
        step();
        check("t5_ptr_zero", 64'(obs_ready), 64'b001);

        // Randomized traffic; requesters hold their operation until accepted.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!(bus.req_valid[i] && !obs_ready[i])) begin
                    logic [W-1:0] a = $urandom;
                    logic [W-1:0] b = ($urandom_range(0, 3) == 0) ? a : $urandom;
                    set_req(i, $urandom_range(0, 99) < 60, 4'($urandom_range(0, 7)),
                            a, b, $urandom_range(0, 7) == 0);
                end
            end
            bus.rsp_ready = $urandom_range(0, 99) < 70;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
